div_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU), which the single-cycle ALU does not execute.
- Sits beside the ALU in the EX stage. Accepts operands plus the 5-bit SELECT code, runs a 32-iteration restoring shift-subtract sequence, and holds the pipeline stalled until the result is ready.
- Applies RISC-V sign, divide-by-zero and overflow rules.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/div_step.sv | 30 +++
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage multi-cycle divide unit: operand width,
// divide SELECT codes and the sequencer state encoding.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int CNT_W     = 5;
  localparam int DIV_ITERS = 32;

  localparam logic [4:0] SEL_DIV  = 5'b01100;
  localparam logic [4:0] SEL_DIVU = 5'b01101;
  localparam logic [4:0] SEL_REM  = 5'b01110;
  localparam logic [4:0] SEL_REMU = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // All four divide ops share the 011xx prefix: bit1 selects remainder, bit0 unsigned.
  function automatic logic is_div_sel(input logic [4:0] sel);
    return sel[4:2] == 3'b011;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on {rem, quo}; purely combinational.
// Requires rem_i < dvsr_i on entry, which keeps the trial difference within W+1 bits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] rem_sh;
  logic [W:0] diff;

  assign rem_sh = {rem_i, quo_i[W-1]};
  assign diff   = rem_sh - {1'b0, dvsr_i};

  // A set top bit of the difference means the trial subtract went negative.
  always_comb begin
    if (diff[W]) begin
      rem_o = rem_sh[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32 CALC clocks + FIX + one-cycle DONE pulse,
// holding STALL high until the result is ready; zero-divisor/overflow finish at acceptance.
module div_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;

  logic            op_rem;
  logic            op_signed;
  logic            accept;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign op_rem    = SELECT[1];
  assign op_signed = ~SELECT[0];
  assign accept    = (state_q == ST_IDLE) && START && is_div_sel(SELECT) && !FLUSH;

  assign mag1 = (op_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
  assign mag2 = (op_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  div_step #(.W(XLEN)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    STALL     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          STALL = 1'b1;
          if (DATA2 == '0) begin
            result_d = op_rem ? DATA1 : ALL_ONE;
            state_d  = ST_DONE;
          end else if (op_signed && DATA1 == INT_MIN && DATA2 == ALL_ONE) begin
            result_d = op_rem ? '0 : INT_MIN;
            state_d  = ST_DONE;
          end else begin
            // Quotient register starts holding the dividend; it shifts out into rem.
            quo_d     = mag1;
            dvsr_d    = mag2;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = op_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            neg_rem_d = op_signed && DATA1[XLEN-1];
            is_rem_d  = op_rem;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        STALL = 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        STALL    = 1'b1;
        result_d = is_rem_q ? rem_fix : quo_fix;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flushed op never completes and never touches RESULT.
    if (FLUSH && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = (state_q == ST_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results are queued at START and
// compared at the DONE pulse, alongside latency, STALL and FLUSH/RESET behaviour.
module tb_div_sequencer;

  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_DIVU = 5'b01101;
  localparam logic [4:0] OP_REM  = 5'b01110;
  localparam logic [4:0] OP_REMU = 5'b01111;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [4:0]  SELECT = '0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        FLUSH = 1'b0;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res = '0;

  always #5 CLK = ~CLK;

  div_sequencer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .FLUSH  (FLUSH),
    .STALL  (STALL),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural RISC-V divide semantics, independent of the shift-subtract datapath.
  function automatic logic [31:0] ref_div(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'h0) return sel[1] ? a : 32'hFFFF_FFFF;
    if (!sel[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return sel[1] ? 32'h0 : 32'h8000_0000;
      return sel[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return sel[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 0;
    if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // k counts clock edges after the accepting edge; pester re-drives START mid-operation.
  task automatic do_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit pester);
    int k;
    int stalls;
    int exp_lat;
    logic [31:0] want;
    exp_lat = ref_lat(sel, a, b);
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    #1 chk({tag, "_stall_acc"}, 32'(STALL), 32'd1);
    sb_q.push_back(exp);
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    stalls = 0;
    while (!DONE && k < 100) begin
      if (STALL) stalls++;
      if (pester && k >= 5 && k < 10) begin
        START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd50; DATA2 = 32'd5;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    START = 1'b0;
    want = sb_q.pop_front();
    if (!DONE) begin
      chk({tag, "_timeout"}, 32'(k), 32'(exp_lat));
    end else begin
      chk({tag, "_result"}, RESULT, want);
      chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
      chk({tag, "_stall_done"}, 32'(STALL), 32'd0);
      last_res = want;
    end
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    if (pester) begin
      k = 0;
      repeat (40) begin
        @(negedge CLK);
        if (DONE) k++;
      end
      chk({tag, "_single_done"}, 32'(k), 32'd0);
    end
  endtask

  initial begin
    int dones;
    logic [4:0]  rsel;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge CLK);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    RESET = 1'b1;

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'h0000_0005, 1'b0);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 1'b0);

    // FLUSH seen at the 10th edge after acceptance.
    @(negedge CLK);
    START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_busy", 32'(BUSY), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("flush_no_done", 32'(dones), 32'd0);
    chk("flush_result_kept", RESULT, last_res);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, 1'b0);

    do_op("busy_start", OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);

    @(negedge CLK);
    START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd8; DATA2 = 32'd2;
    #1 chk("badsel_stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    chk("badsel_busy", 32'(BUSY), 32'd0);
    START = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rsel = {3'b011, 2'($urandom_range(0, 3))};
      ra   = $urandom;
      rb   = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      do_op("rand", rsel, ra, rb, ref_div(rsel, ra, rb), 1'b0);
    end

    // Reset at edge 20 of a DIV, together with FLUSH.
    @(negedge CLK);
    START = 1'b1; SELECT = OP_DIV; DATA1 = 32'hFFFF_FF00; DATA2 = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (19) @(negedge CLK);
    RESET = 1'b0; FLUSH = 1'b1;
    @(negedge CLK);
    chk("midrst_stall", 32'(STALL), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_result", RESULT, 32'd0);
    RESET = 1'b1; FLUSH = 1'b0;
    last_res = '0;
    do_op("post_rst", OP_REM, 32'd17, 32'd5, 32'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
